obstacle_field: RTL

Time-multiplexed position engine for N_OBJ horizontally scrolling obstacles. It replaces per-obstacle mover instances in the game graphics path. On each animation strobe it runs one sweep that updates every obstacle in turn, one per clock. The sweep applies a programmable speed, wraps each obstacle around the screen horizontally and flags every wrap, so scoring logic can count passed obstacles. It drives edge coordinates for all obstacles in parallel to the VGA draw/collision logic.

---
 rtl/obstacle_field.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_field.sv
// obstacle_field: time-multiplexed position engine for N_OBJ horizontally
// scrolling obstacles. One animation strobe starts a sweep that updates one
// obstacle per clock, wrapping each around a virtual span of
// D_WIDTH + 2*H_WIDTH and pulsing o_wrap for each wrap.
//
// Optional feature macro: OBSTACLE_VBOUNCE_EN
//   defined   -> each update also moves y by 1 px, bouncing between
//                H_HEIGHT and D_HEIGHT-H_HEIGHT-1.
//   undefined -> y is fixed at its reset value (no bounce logic).
//
// Handshake: i_ani_stb is a single-cycle strobe; it starts a sweep only in
// IDLE with i_animate high. A strobe seen while busy is dropped and reported
// on o_overrun. o_busy, o_frame_done, o_wrap and o_overrun come from
// registered state, so they are stable for the whole cycle.
module obstacle_field #(
  parameter int N_OBJ    = 4,
  parameter int H_WIDTH  = 20,
  parameter int H_HEIGHT = 15,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480,
  parameter int IP0      = 40,
  parameter int SPACING  = 170,
  parameter int IY0      = 60,
  parameter int LANE_DY  = 120,
  parameter int DIR      = 1,
  parameter int SPEED_W  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ani_stb,
  input  logic                 i_animate,
  input  logic [SPEED_W-1:0]   i_speed,
  output logic [12*N_OBJ-1:0]  o_x1,
  output logic [12*N_OBJ-1:0]  o_x2,
  output logic [12*N_OBJ-1:0]  o_y1,
  output logic [12*N_OBJ-1:0]  o_y2,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [N_OBJ-1:0]     o_wrap,
  output logic                 o_overrun
);

  localparam int              X_SPAN   = D_WIDTH + 2 * H_WIDTH;
  localparam int              IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [12:0]     X_SPAN_V = 13'(X_SPAN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Reset position of obstacle k, folded into the wrap span.
  function automatic logic [11:0] init_p(input int k);
    return 12'((IP0 + k * SPACING) % X_SPAN);
  endfunction

  // Reset centre y of obstacle k.
  function automatic logic [11:0] init_y(input int k);
    return 12'(IY0 + k * LANE_DY);
  endfunction

  // FSM state is kept in state_q for probing alongside idx_q.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [11:0]        p_q [N_OBJ];
  logic [11:0]        p_d [N_OBJ];
  logic [N_OBJ-1:0]   wrap_q, wrap_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;

  logic [11:0]        y_cur [N_OBJ];

  logic [11:0]        p_sel;
  logic [11:0]        p_new;
  logic               wrap_new;
  logic [12:0]        spd_ext;
  logic [12:0]        p_ext;
  logic [12:0]        sum;

  // Select the obstacle under update and compute its next position.
  always_comb begin
    p_sel    = '0;
    p_new    = '0;
    wrap_new = 1'b0;
    sum      = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (idx_q == IDX_W'(k)) p_sel = p_q[k];
    end
    spd_ext = 13'(spd_q);
    p_ext   = {1'b0, p_sel};
    if (DIR != 0) begin
      sum = p_ext + spd_ext;
      if (sum >= X_SPAN_V) begin
        p_new    = 12'(sum - X_SPAN_V);
        wrap_new = 1'b1;
      end else begin
        p_new = sum[11:0];
      end
    end else begin
      if (p_ext < spd_ext) begin
        p_new    = 12'(p_ext + X_SPAN_V - spd_ext);
        wrap_new = 1'b1;
      end else begin
        p_new = 12'(p_ext - spd_ext);
      end
    end
  end

  // Sweep FSM next-state and pulse outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    spd_d        = spd_q;
    p_d          = p_q;
    wrap_d       = '0;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ani_stb && i_animate) begin
          spd_d   = i_speed;
          idx_d   = '0;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        // A strobe while busy is not queued; the sweep keeps its latched speed.
        if (i_ani_stb) overrun_d = 1'b1;
        for (int k = 0; k < N_OBJ; k++) begin
          if (idx_q == IDX_W'(k)) begin
            p_d[k]    = p_new;
            wrap_d[k] = wrap_new;
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset wins over any sweep in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      spd_q        <= '0;
      wrap_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < N_OBJ; k++) p_q[k] <= init_p(k);
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      spd_q        <= spd_d;
      wrap_q       <= wrap_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      for (int k = 0; k < N_OBJ; k++) p_q[k] <= p_d[k];
    end
  end

`ifdef OBSTACLE_VBOUNCE_EN
  localparam logic [11:0] Y_MIN = 12'(H_HEIGHT);
  localparam logic [11:0] Y_MAX = 12'(D_HEIGHT - H_HEIGHT - 1);

  logic [11:0] y_q [N_OBJ];
  logic [11:0] y_d [N_OBJ];
  logic        ydir_q [N_OBJ];
  logic        ydir_d [N_OBJ];
  logic [11:0] y_sel;
  logic        ydir_sel;
  logic        dir_eff;
  logic [11:0] y_new;
  logic        ydir_new;

  // One-pixel vertical step with direction flip on reaching a limit.
  always_comb begin
    y_sel    = '0;
    ydir_sel = 1'b0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (idx_q == IDX_W'(k)) begin
        y_sel    = y_q[k];
        ydir_sel = ydir_q[k];
      end
    end
    // An obstacle already sitting on a limit always steps back inside.
    dir_eff = ydir_sel;
    if (y_sel >= Y_MAX) dir_eff = 1'b0;
    if (y_sel <= Y_MIN) dir_eff = 1'b1;
    y_new    = dir_eff ? (y_sel + 12'd1) : (y_sel - 12'd1);
    ydir_new = dir_eff;
    if (y_new >= Y_MAX) ydir_new = 1'b0;
    if (y_new <= Y_MIN) ydir_new = 1'b1;
    y_d    = y_q;
    ydir_d = ydir_q;
    if (state_q == ST_SWEEP) begin
      for (int k = 0; k < N_OBJ; k++) begin
        if (idx_q == IDX_W'(k)) begin
          y_d[k]    = y_new;
          ydir_d[k] = ydir_new;
        end
      end
    end
  end

  // Vertical state registers; even obstacles start moving down.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_OBJ; k++) begin
        y_q[k]    <= init_y(k);
        ydir_q[k] <= ((k % 2) == 0);
      end
    end else begin
      for (int k = 0; k < N_OBJ; k++) begin
        y_q[k]    <= y_d[k];
        ydir_q[k] <= ydir_d[k];
      end
    end
  end

  // Current y is the bouncing register.
  always_comb begin
    for (int k = 0; k < N_OBJ; k++) y_cur[k] = y_q[k];
  end
`else
  // Without bounce, y is a constant per obstacle.
  always_comb begin
    for (int k = 0; k < N_OBJ; k++) y_cur[k] = init_y(k);
  end
`endif

  // Edge coordinates for every obstacle, 12-bit modulo.
  always_comb begin
    for (int k = 0; k < N_OBJ; k++) begin
      o_x1[12*k +: 12] = p_q[k] - 12'(2 * H_WIDTH);
      o_x2[12*k +: 12] = p_q[k];
      o_y1[12*k +: 12] = y_cur[k] - 12'(H_HEIGHT);
      o_y2[12*k +: 12] = y_cur[k] + 12'(H_HEIGHT);
    end
  end

  assign o_busy       = (state_q == ST_SWEEP);
  assign o_frame_done = frame_done_q;
  assign o_wrap       = wrap_q;
  assign o_overrun    = overrun_q;

endmodule
